// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM state encodings
// and the memory-map defaults used by the top level.
package sram_mem_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_WAIT_CYCLES = 5;
    localparam int unsigned DEFAULT_DATA_BASE   = 1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase cycle counter: clears to zero, otherwise counts up every cycle;
// terminal is high on the last cycle of a phase (count == WAIT_CYCLES-1).
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic terminal
);

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit load/store into two timed half-word SRAM accesses and
// freezes the pipeline via ready. Optional stall counter: SRAM_STALL_COUNT_EN.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned DATA_BASE   = DEFAULT_DATA_BASE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    input  logic [31:0]           address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [15:0]           sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [15:0]           sram_dq_in,
    output logic                  sram_we_n,
    output logic [31:0]           stall_count
);

    state_t state, next_state;

    logic                  req;
    logic                  is_read;
    logic                  terminal;
    logic                  wait_clear;
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] half_base;
    logic                  unused_offset;

    assign req     = mem_r_en | mem_w_en;
    // A simultaneous read+write is treated as a pure write.
    assign is_read = mem_r_en & ~mem_w_en;

    assign offset        = address - 32'(DATA_BASE);
    assign half_base     = {offset[ADDR_WIDTH:2], 1'b0};
    assign unused_offset = ^{offset[31:ADDR_WIDTH+1], offset[1:0]};

    assign wait_clear = (state == IDLE) || (state == DONE) || terminal;

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (wait_clear),
        .terminal(terminal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        unique case (state)
            IDLE: begin
                // Gated by rst so a held request cannot pull ready low during reset.
                ready = !(req && rst);
                if (req) next_state = LOW;
            end
            LOW: begin
                sram_addr = half_base;
                if (mem_w_en) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = write_data[15:0];
                    sram_we_n   = terminal;
                end
                if (terminal) next_state = HIGH;
            end
            HIGH: begin
                sram_addr = {half_base[ADDR_WIDTH-1:1], 1'b1};
                if (mem_w_en) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = write_data[31:16];
                    sram_we_n   = terminal;
                end
                if (terminal) next_state = DONE;
            end
            DONE: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
        end else if (is_read && terminal) begin
            if (state == LOW)  read_data[15:0]  <= sram_dq_in;
            if (state == HIGH) read_data[31:16] <= sram_dq_in;
        end
    end

`ifdef SRAM_STALL_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (!ready && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign stall_count = '0;
`endif

endmodule
